// File: rtl/tx_frame_arbiter.sv
// Burst arbiter feeding the shared UART transmit FIFO from the CPU A and CPU B
// receive FIFOs; a grant lasts until an idle gap or the byte limit closes the burst.
module tx_frame_arbiter #(
   parameter int FIFO_CNT_W = 5,
   parameter int TX_DEPTH   = 16,
   parameter int IDLE_GAP   = 320,
   parameter int MAX_BURST  = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  switch,
   input  logic [7:0]            a_rdr,
   input  logic [FIFO_CNT_W-1:0] a_rf_counter,
   output logic                  a_rf_pop,
   input  logic [7:0]            b_rdr,
   input  logic [FIFO_CNT_W-1:0] b_rf_counter,
   output logic                  b_rf_pop,
   input  logic [FIFO_CNT_W-1:0] tf_counter,
   output logic                  tf_push,
   output logic [7:0]            tdr,
   output logic [1:0]            grant,
   output logic                  busy
);

   localparam int IDLE_W = $clog2(IDLE_GAP + 1);
   localparam logic [IDLE_W-1:0]     IDLE_LIMIT  = IDLE_W'(IDLE_GAP);
   localparam logic [7:0]            BURST_LIMIT = 8'(MAX_BURST);
   localparam logic [FIFO_CNT_W-1:0] TX_FULL     = FIFO_CNT_W'(TX_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_XFER    = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_A    = 2'd1,
      OWN_B    = 2'd2
   } owner_t;

   state_t              r_state;
   state_t              w_next_state;
   owner_t              r_last_owner;
   owner_t              w_nxt_last;
   logic                r_owner_b;
   logic                w_nxt_owner_b;
   logic [IDLE_W-1:0]   r_idle_cnt;
   logic [IDLE_W-1:0]   w_nxt_idle;
   logic [7:0]          r_burst_cnt;
   logic [7:0]          w_nxt_burst;
   logic                r_tf_push;
   logic                r_a_pop;
   logic                r_b_pop;
   logic [7:0]          r_tdr;
   logic [1:0]          r_grant;
   logic                r_busy;
   logic                w_nxt_tf_push;
   logic                w_nxt_a_pop;
   logic                w_nxt_b_pop;
   logic [7:0]          w_nxt_tdr;
   logic [1:0]          w_nxt_grant;

   logic                  w_req_a;
   logic                  w_req_b;
   logic                  w_pick_b;
   logic [FIFO_CNT_W-1:0] w_own_cnt;
   logic [7:0]            w_own_rdr;
   logic                  w_own_req;
   logic                  w_tx_full;
   logic                  w_close;
   logic                  w_issue;

   assign w_req_a = (a_rf_counter != '0);
   assign w_req_b = (b_rf_counter != '0);

   // B wins when alone, when A owned the previous burst, or on the very first
   // contended arbitration when B is the host.
   assign w_pick_b = w_req_b &&
                     (!w_req_a ||
                      (r_last_owner == OWN_A) ||
                      ((r_last_owner == OWN_NONE) && switch));

   assign w_own_cnt = r_owner_b ? b_rf_counter : a_rf_counter;
   assign w_own_rdr = r_owner_b ? b_rdr : a_rdr;
   assign w_own_req = (w_own_cnt != '0);
   assign w_tx_full = (tf_counter >= TX_FULL);

   // A full transmit FIFO freezes the burst entirely, including its closing.
   assign w_close = !w_tx_full &&
                    ((r_burst_cnt >= BURST_LIMIT) || (r_idle_cnt >= IDLE_LIMIT));

   // The previous-cycle pulse check hides the one-cycle lag of the source counter.
   assign w_issue = (r_state == ST_XFER) && !w_close && w_own_req &&
                    !w_tx_full && !r_tf_push;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_req_a || w_req_b) begin
               w_next_state = ST_XFER;
            end
         end
         ST_XFER: begin
            if (w_close) begin
               w_next_state = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      w_nxt_tf_push = 1'b0;
      w_nxt_a_pop   = 1'b0;
      w_nxt_b_pop   = 1'b0;
      w_nxt_tdr     = r_tdr;
      w_nxt_grant   = r_grant;
      w_nxt_owner_b = r_owner_b;
      w_nxt_last    = r_last_owner;
      w_nxt_idle    = r_idle_cnt;
      w_nxt_burst   = r_burst_cnt;
      case (r_state)
         ST_IDLE: begin
            w_nxt_idle  = '0;
            w_nxt_burst = '0;
            if (w_req_a || w_req_b) begin
               w_nxt_owner_b = w_pick_b;
               w_nxt_grant   = w_pick_b ? 2'b10 : 2'b01;
            end
         end
         ST_XFER: begin
            if (w_close) begin
               w_nxt_grant = 2'b00;
            end else begin
               if (w_issue) begin
                  w_nxt_tf_push = 1'b1;
                  w_nxt_a_pop   = !r_owner_b;
                  w_nxt_b_pop   = r_owner_b;
                  w_nxt_tdr     = w_own_rdr;
                  if (r_burst_cnt != 8'hFF) begin
                     w_nxt_burst = r_burst_cnt + 8'd1;
                  end
               end
               if (!w_tx_full) begin
                  if (w_own_req) begin
                     w_nxt_idle = '0;
                  end else if (r_idle_cnt < IDLE_LIMIT) begin
                     w_nxt_idle = r_idle_cnt + IDLE_W'(1);
                  end
               end
            end
         end
         ST_RELEASE: begin
            w_nxt_grant = 2'b00;
            w_nxt_last  = r_owner_b ? OWN_B : OWN_A;
         end
         default: begin
            w_nxt_grant = 2'b00;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tf_push    <= 1'b0;
         r_a_pop      <= 1'b0;
         r_b_pop      <= 1'b0;
         r_tdr        <= 8'h00;
         r_grant      <= 2'b00;
         r_busy       <= 1'b0;
         r_owner_b    <= 1'b0;
         r_last_owner <= OWN_NONE;
         r_idle_cnt   <= '0;
         r_burst_cnt  <= '0;
      end else begin
         r_tf_push    <= w_nxt_tf_push;
         r_a_pop      <= w_nxt_a_pop;
         r_b_pop      <= w_nxt_b_pop;
         r_tdr        <= w_nxt_tdr;
         r_grant      <= w_nxt_grant;
         r_busy       <= |w_nxt_grant;
         r_owner_b    <= w_nxt_owner_b;
         r_last_owner <= w_nxt_last;
         r_idle_cnt   <= w_nxt_idle;
         r_burst_cnt  <= w_nxt_burst;
      end
   end

   assign tf_push  = r_tf_push;
   assign a_rf_pop = r_a_pop;
   assign b_rf_pop = r_b_pop;
   assign tdr      = r_tdr;
   assign grant    = r_grant;
   assign busy     = r_busy;

endmodule
